edge_event_bank: RTL and testbench

Multi-channel, parametrised edge detector for asynchronous inputs such as push-buttons, switches and external strobes. Each channel has a configurable synchronizer, a glitch/debounce filter, a per-channel edge mode (rising, falling or both) and a sticky pending flag with clear. It sits between raw board inputs and the control FSMs. Consumers get a one-cycle `pulse` per detected event, or poll and clear `pending` and `irq`.

---
 rtl/edge_event_bank.sv | 130 +++++++++++++
 tb/tb_edge_event_bank.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_bank.sv
// edge_event_bank
//
// Multi-channel edge detector for asynchronous board inputs (buttons,
// switches, external strobes). Each channel runs through a plain
// synchronizer chain, then a debounce filter that only accepts a change
// once it has persisted for DEBOUNCE_CYCLES consecutive cycles. Accepted
// changes are qualified against a per-channel edge mode. Qualified events
// drive a one-cycle strobe and a sticky pending flag.
//
// This block has no handshake and no FSM. All per-channel state (sync
// chain, debounce counter, level, pulse, pending) is visible either on the
// ports or in the named *_q registers.
//
// Parameters:
//   CHANNELS        number of independent channels (>= 1)
//   SYNC_STAGES     synchronizer flops per channel (>= 2)
//   DEBOUNCE_CYCLES cycles a synchronized change must persist (>= 1)
//   RESET_LEVEL     value loaded into sync stages and level at reset
//
// Ports:
//   clk            single clock, rising edge
//   async_reset    asynchronous active-high reset
//   signal_input   raw asynchronous inputs, bit i = channel i
//   mode           [2i+1:2i] per channel: 00 off, 01 rise, 10 fall, 11 both
//   clear          synchronous clear of pending, one bit per channel
//   level          filtered, debounced level (registered)
//   pulse          one-cycle event strobe (registered)
//   pending        sticky event flag (registered)
//   irq            OR of all pending bits (combinational)

module edge_event_bank #(
  parameter int   CHANNELS        = 4,
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 1,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic                  clk,
  input  logic                  async_reset,
  input  logic [CHANNELS-1:0]   signal_input,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clear,
  output logic [CHANNELS-1:0]   level,
  output logic [CHANNELS-1:0]   pulse,
  output logic [CHANNELS-1:0]   pending,
  output logic                  irq
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Synchronizer chain: stage 0 samples the raw input, the last stage is
  // the synchronized value used by the filter.
  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_d [SYNC_STAGES];

  logic [CNT_W-1:0]    cnt_q  [CHANNELS];
  logic [CNT_W-1:0]    cnt_d  [CHANNELS];

  logic [CHANNELS-1:0] level_q,   level_d;
  logic [CHANNELS-1:0] pulse_q,   pulse_d;
  logic [CHANNELS-1:0] pending_q, pending_d;

  logic [CHANNELS-1:0] sync_out;
  logic [CHANNELS-1:0] rise_evt;
  logic [CHANNELS-1:0] fall_evt;

  always_comb begin
    sync_d[0] = signal_input;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    level_d   = level_q;
    pulse_d   = '0;
    pending_d = '0;
    rise_evt  = '0;
    fall_evt  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = '0;
      if (sync_out[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          // Change has persisted for the full window: accept it.
          level_d[i]  = sync_out[i];
          rise_evt[i] = sync_out[i];
          fall_evt[i] = ~sync_out[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
      // A bounce back to the old level leaves cnt_d at 0, restarting the window.
      pulse_d[i]   = (rise_evt[i] & mode[2*i]) | (fall_evt[i] & mode[2*i+1]);
      // A new event in the same cycle as clear wins so no event is lost.
      pending_d[i] = pulse_d[i] | (pending_q[i] & ~clear[i]);
    end
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= {CHANNELS{RESET_LEVEL}};
      end
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
      level_q   <= {CHANNELS{RESET_LEVEL}};
      pulse_q   <= '0;
      pending_q <= '0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      level_q   <= level_d;
      pulse_q   <= pulse_d;
      pending_q <= pending_d;
    end
  end

  assign level   = level_q;
  assign pulse   = pulse_q;
  assign pending = pending_q;
  assign irq     = |pending_q;

endmodule

// File: tb/tb_edge_event_bank.sv
// Directed bench for edge_event_bank with CHANNELS=4, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=3, RESET_LEVEL=0. An input change sampled at edge k
// shows on level/pulse at edge k+4.
module tb_edge_event_bank;

  logic       clk = 1'b0;
  logic       async_reset;
  logic [3:0] signal_input;
  logic [7:0] mode;
  logic [3:0] clear;
  logic [3:0] level;
  logic [3:0] pulse;
  logic [3:0] pending;
  logic       irq;

  int checks   = 0;
  int failures = 0;

  // Expected pulse vector per upcoming cycle.
  logic [3:0] exp_q[$];

  // Clock / reset
  always #5 clk = ~clk;

  edge_event_bank #(
    .CHANNELS        (4),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (3),
    .RESET_LEVEL     (1'b0)
  ) dut (
    .clk          (clk),
    .async_reset  (async_reset),
    .signal_input (signal_input),
    .mode         (mode),
    .clear        (clear),
    .level        (level),
    .pulse        (pulse),
    .pending      (pending),
    .irq          (irq)
  );

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected pulse pattern for one accepted change sampled at the next edge.
  task automatic push_edge(input logic [3:0] p);
    repeat (4) exp_q.push_back(4'b0000);
    exp_q.push_back(p);
    exp_q.push_back(4'b0000);
  endtask

  task automatic push_quiet(input int n);
    repeat (n) exp_q.push_back(4'b0000);
  endtask

  // Scoreboard: one tick per expected entry, compare pulse.
  task automatic run_window(input string tag);
    logic [3:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      check(tag, pulse, e);
    end
  endtask

  initial begin
    async_reset  = 1'b1;
    signal_input = 4'b0000;
    mode         = 8'b11_10_11_01;
    clear        = 4'b0000;
    tick();
    tick();
    check("rst_level",   level,   4'b0000);
    check("rst_pulse",   pulse,   4'b0000);
    check("rst_pending", pending, 4'b0000);
    check("rst_irq",     {3'b000, irq}, 4'b0000);
    async_reset = 1'b0;

    // 1: rising-only on channel 0
    signal_input = 4'b0001;
    push_edge(4'b0001);
    run_window("t1_rise_pulse");
    check("t1_level",   level,   4'b0001);
    check("t1_pending", pending, 4'b0001);
    check("t1_irq",     {3'b000, irq}, 4'b0001);
    signal_input = 4'b0000;
    push_quiet(6);
    run_window("t1_fall_nopulse");
    check("t1_level_low",   level,   4'b0000);
    check("t1_pending_kept", pending, 4'b0001);
    clear = 4'b0001;
    tick();
    clear = 4'b0000;
    check("t1_cleared", pending, 4'b0000);
    check("t1_irq_low", {3'b000, irq}, 4'b0000);

    // 2: glitch rejection then accepted pulse on channel 1 (mode 11)
    signal_input = 4'b0010;
    tick();
    tick();
    signal_input = 4'b0000;
    push_quiet(6);
    run_window("t2_glitch");
    check("t2_glitch_level",   level,   4'b0000);
    check("t2_glitch_pending", pending, 4'b0000);
    signal_input = 4'b0010;
    push_quiet(4);
    exp_q.push_back(4'b0010);
    run_window("t2_rise");
    check("t2_level_high", level, 4'b0010);
    signal_input = 4'b0000;
    push_edge(4'b0010);
    run_window("t2_fall");
    check("t2_level_low", level,   4'b0000);
    check("t2_pending",   pending, 4'b0010);
    clear = 4'b0010;
    tick();
    clear = 4'b0000;

    // 3: falling-only on channel 2, then mode 00
    signal_input = 4'b0100;
    push_quiet(6);
    run_window("t3_rise_nopulse");
    check("t3_level_high", level,   4'b0100);
    check("t3_no_pending", pending, 4'b0000);
    signal_input = 4'b0000;
    push_edge(4'b0100);
    run_window("t3_fall");
    check("t3_pending", pending, 4'b0100);
    clear = 4'b0100;
    mode  = 8'b11_00_11_01;
    tick();
    clear = 4'b0000;
    signal_input = 4'b0100;
    push_quiet(6);
    run_window("t3_off_rise");
    check("t3_off_level_high", level, 4'b0100);
    signal_input = 4'b0000;
    push_quiet(6);
    run_window("t3_off_fall");
    check("t3_off_level_low", level,   4'b0000);
    check("t3_off_pending",   pending, 4'b0000);

    // 4: clear coincident with a new event on channel 3
    signal_input = 4'b1000;
    push_edge(4'b1000);
    run_window("t4_rise");
    check("t4_pending_set", pending, 4'b1000);
    signal_input = 4'b0000;
    push_quiet(4);
    run_window("t4_pre_fall");
    clear = 4'b1000;
    tick();
    check("t4_fall_pulse", pulse,   4'b1000);
    check("t4_set_wins",   pending, 4'b1000);
    tick();
    clear = 4'b0000;
    check("t4_clear_only", pending, 4'b0000);
    check("t4_irq_low",    {3'b000, irq}, 4'b0000);
    check("t4_pulse_done", pulse,   4'b0000);

    // 5: simultaneous events on channels 0 and 3
    mode = 8'b11_00_11_11;
    signal_input = 4'b1001;
    push_edge(4'b1001);
    run_window("t5_rise");
    check("t5_pending", pending, 4'b1001);
    check("t5_level",   level,   4'b1001);
    signal_input = 4'b0000;
    push_edge(4'b1001);
    run_window("t5_fall");
    check("t5_level_low", level, 4'b0000);
    clear = 4'b1111;
    tick();
    clear = 4'b0000;
    check("t5_cleared", pending, 4'b0000);

    // 6: asynchronous reset mid-debounce on channel 0
    signal_input = 4'b1000;
    push_edge(4'b1000);
    run_window("t6_setup");
    check("t6_pre_level",   level,   4'b1000);
    check("t6_pre_pending", pending, 4'b1000);
    signal_input = 4'b1001;
    tick();
    tick();
    tick();
    #2;
    async_reset = 1'b1;
    #1;
    check("t6_async_level",   level,   4'b0000);
    check("t6_async_pulse",   pulse,   4'b0000);
    check("t6_async_pending", pending, 4'b0000);
    check("t6_async_irq",     {3'b000, irq}, 4'b0000);
    tick();
    async_reset = 1'b0;
    push_edge(4'b1001);
    run_window("t6_post_reset");
    check("t6_pending", pending, 4'b1001);
    check("t6_irq",     {3'b000, irq}, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
